// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: default geometry, address width, colours and
// the write-arbiter state encoding.
package fb_pkg;

  localparam int unsigned BITS_PER_PIXEL_DEF    = 3;
  localparam int unsigned FRAMEBUFFER_DEPTH_DEF = 640 * 480;
  localparam int unsigned FB_ADDR_W             = 32;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] BLACK = 3'b000;

  typedef enum logic {
    StArb  = 1'b0,
    StFill = 1'b1
  } fb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer
// that moves only when a grant is actually consumed.
module rr_arbiter2 (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Req_A,
  input  logic i_Req_B,
  input  logic i_Advance,
  output logic o_Gnt_A,
  output logic o_Gnt_B
);

  // High when A won the most recent transfer, so B is favoured next.
  logic last_a_q;

  assign o_Gnt_A = i_Req_A && (!i_Req_B || !last_a_q);
  assign o_Gnt_B = i_Req_B && (!i_Req_A || last_a_q);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      last_a_q <= 1'b0;
    end else if (i_Advance) begin
      last_a_q <= o_Gnt_A;
    end
  end

endmodule

// File: rtl/framebuffer_write_arbiter.sv
// Sole owner of the framebuffer write port: round-robin between two requesters
// plus a full-buffer fill sequencer, one registered write per clock.
module framebuffer_write_arbiter #(
  parameter int unsigned BITS_PER_PIXEL    = fb_pkg::BITS_PER_PIXEL_DEF,
  parameter int unsigned FRAMEBUFFER_DEPTH = fb_pkg::FRAMEBUFFER_DEPTH_DEF
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset_n,
  input  logic                         i_Fill_Start,
  input  logic [BITS_PER_PIXEL-1:0]    i_Fill_Color,
  output logic                         o_Fill_Busy,
  output logic                         o_Fill_Done,
  input  logic                         i_A_Valid,
  input  logic [fb_pkg::FB_ADDR_W-1:0] i_A_Addr,
  input  logic [BITS_PER_PIXEL-1:0]    i_A_Data,
  output logic                         o_A_Ready,
  input  logic                         i_B_Valid,
  input  logic [fb_pkg::FB_ADDR_W-1:0] i_B_Addr,
  input  logic [BITS_PER_PIXEL-1:0]    i_B_Data,
  output logic                         o_B_Ready,
  output logic                         o_Drop,
  output logic                         o_Write_Enable,
  output logic [fb_pkg::FB_ADDR_W-1:0] o_Write_Addr,
  output logic [BITS_PER_PIXEL-1:0]    o_Write_Data
);

  import fb_pkg::*;

  localparam int unsigned CntW = (FRAMEBUFFER_DEPTH > 1) ? $clog2(FRAMEBUFFER_DEPTH) : 1;
  localparam logic [CntW-1:0]      LastCnt = CntW'(FRAMEBUFFER_DEPTH - 1);
  localparam logic [FB_ADDR_W-1:0] DepthW  = FB_ADDR_W'(FRAMEBUFFER_DEPTH);

  fb_state_e                 state_q, state_d;
  logic [CntW-1:0]           fill_cnt_q, fill_cnt_d;
  logic [BITS_PER_PIXEL-1:0] fill_color_q, fill_color_d;
  logic                      we_q, we_d;
  logic [FB_ADDR_W-1:0]      addr_q, addr_d;
  logic [BITS_PER_PIXEL-1:0] data_q, data_d;
  logic                      drop_q, drop_d;
  logic                      done_q, done_d;

  logic                      gnt_a, gnt_b;
  logic                      arb_en;
  logic                      advance;
  logic [FB_ADDR_W-1:0]      sel_addr;
  logic [BITS_PER_PIXEL-1:0] sel_data;

  // A fill start in the same cycle pre-empts any requester; it keeps its request held.
  assign arb_en   = (state_q == StArb) && !i_Fill_Start;
  assign o_A_Ready = arb_en && gnt_a;
  assign o_B_Ready = arb_en && gnt_b;
  assign advance  = arb_en && (gnt_a || gnt_b);
  assign sel_addr = gnt_a ? i_A_Addr : i_B_Addr;
  assign sel_data = gnt_a ? i_A_Data : i_B_Data;

  rr_arbiter2 u_rr_arbiter2 (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Req_A   (i_A_Valid),
    .i_Req_B   (i_B_Valid),
    .i_Advance (advance),
    .o_Gnt_A   (gnt_a),
    .o_Gnt_B   (gnt_b)
  );

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    fill_color_d = fill_color_q;
    we_d         = 1'b0;
    addr_d       = '0;
    data_d       = '0;
    drop_d       = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      StArb: begin
        if (i_Fill_Start) begin
          // Address 0 is issued on the start edge; the counter tracks the address on the port.
          state_d      = StFill;
          fill_cnt_d   = '0;
          fill_color_d = i_Fill_Color;
          we_d         = 1'b1;
          data_d       = i_Fill_Color;
        end else if (advance) begin
          if (sel_addr < DepthW) begin
            we_d   = 1'b1;
            addr_d = sel_addr;
            data_d = sel_data;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      StFill: begin
        if (fill_cnt_q == LastCnt) begin
          state_d    = StArb;
          fill_cnt_d = '0;
          done_d     = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          we_d       = 1'b1;
          addr_d     = FB_ADDR_W'(fill_cnt_q + 1'b1);
          data_d     = fill_color_q;
        end
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= StArb;
      fill_cnt_q   <= '0;
      fill_color_q <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      drop_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_color_q <= fill_color_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      drop_q       <= drop_d;
      done_q       <= done_d;
    end
  end

  assign o_Fill_Busy    = (state_q == StFill);
  assign o_Fill_Done    = done_q;
  assign o_Drop         = drop_q;
  assign o_Write_Enable = we_q;
  assign o_Write_Addr   = addr_q;
  assign o_Write_Data   = data_q;

endmodule
